decode_stage: RTL and testbench

Decode stage sitting directly downstream of the fetch stage and upstream of execute. Accepts one fetched instruction per cycle (exec mask, PC, 32-bit instruction word) over a valid/busy handshake and splits the word into opcode, register and immediate fields. It classifies the instruction (control-flow, memory) and presents a registered decoded packet to execute through a 2-entry skid buffer, so back-pressure never creates a combinational path from execute to fetch.

---
 rtl/decode_pkg.sv | 77 +++++++
 rtl/decode_skid_buffer.sv | 53 +++++
 rtl/decode_stage.sv | 88 ++++++++
 tb/tb_decode_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode map, decoded record, field positions.
// DECODE_ILLEGAL_TRAP_EN adds an illegal-opcode flag to the decoded record.
package decode_pkg;

    typedef enum logic [7:0] {
        NOP               = 8'h00,
        ADD               = 8'h01,
        SUB               = 8'h02,
        MUL               = 8'h03,
        AND_OP            = 8'h04,
        OR_OP             = 8'h05,
        XOR_OP            = 8'h06,
        SHL               = 8'h07,
        SHR               = 8'h08,
        MOV_IMM           = 8'h09,
        LOAD              = 8'h10,
        STORE             = 8'h11,
        LOAD_RESTORE_PC   = 8'h12,
        HALT              = 8'h20,
        JMP_ALWAYS        = 8'h21,
        JMP_EQUAL         = 8'h22,
        JMP_NOT_EQUAL     = 8'h23,
        JMP_GREATER       = 8'h24,
        JMP_GREATER_EQUAL = 8'h25,
        JMP_LOWER         = 8'h26,
        JMP_LOWER_EQUAL   = 8'h27
    } opcode_e;

    localparam int OPC_LSB  = 0;
    localparam int OPC_W    = 8;
    localparam int REG_W    = 4;
    localparam int DST_LSB  = 8;
    localparam int SRC1_LSB = 12;
    localparam int SRC2_LSB = 16;
    localparam int IMM_LSB  = 16;
    localparam int IMM_W    = 16;

    typedef struct packed {
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic        illegal;
`endif
        logic        is_branch;
        logic        is_mem;
        logic [31:0] imm;
        logic [3:0]  src2;
        logic [3:0]  src1;
        logic [3:0]  dst;
        logic [7:0]  opcode;
    } decoded_insn_t;

    function automatic logic is_control_flow(input logic [7:0] op);
        case (op)
            HALT, JMP_ALWAYS, JMP_EQUAL, JMP_NOT_EQUAL,
            JMP_GREATER, JMP_GREATER_EQUAL, JMP_LOWER,
            JMP_LOWER_EQUAL, LOAD_RESTORE_PC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_memory_op(input logic [7:0] op);
        case (op)
            LOAD, STORE, LOAD_RESTORE_PC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_defined_op(input logic [7:0] op);
        case (op)
            NOP, ADD, SUB, MUL, AND_OP, OR_OP, XOR_OP, SHL, SHR,
            MOV_IMM, LOAD, STORE, LOAD_RESTORE_PC, HALT,
            JMP_ALWAYS, JMP_EQUAL, JMP_NOT_EQUAL, JMP_GREATER,
            JMP_GREATER_EQUAL, JMP_LOWER, JMP_LOWER_EQUAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_skid_buffer.sv
// Two-entry FIFO between decode and execute; busy comes from the
// registered count only, so execute stalls never reach fetch combinationally.
module decode_skid_buffer #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_busy,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_busy,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         head;
    logic         tail;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign in_busy   = (count == 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && !in_busy;
    assign pop       = out_valid && !out_busy;
    assign out_data  = mem[head];

    // Storage, pointers and occupancy; simultaneous push/pop keeps count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[tail] <= in_data;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: splits the instruction word and classifies it, then
// buffers the record for execute. DECODE_ILLEGAL_TRAP_EN adds out_illegal.
module decode_stage
    import decode_pkg::*;
#(
    parameter int NUM_THREADS = 8,
    parameter int ADDR_W      = 32,
    parameter int INSN_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_busy,
    input  logic [NUM_THREADS-1:0] in_exec_mask,
    input  logic [ADDR_W-1:0]      in_pc,
    input  logic [INSN_W-1:0]      in_insn,
    output logic                   out_valid,
    input  logic                   out_busy,
    output logic [NUM_THREADS-1:0] out_exec_mask,
    output logic [ADDR_W-1:0]      out_pc,
    output logic [7:0]             out_opcode,
    output logic [3:0]             out_dst,
    output logic [3:0]             out_src1,
    output logic [3:0]             out_src2,
    output logic [31:0]            out_imm,
    output logic                   out_is_branch,
    output logic                   out_is_mem
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic                   out_illegal
`endif
);

    localparam int W = NUM_THREADS + ADDR_W + $bits(decoded_insn_t);

    decoded_insn_t dec;
    decoded_insn_t head;
    logic [W-1:0]  buf_in;
    logic [W-1:0]  buf_out;

    // Field extraction and classification of the incoming word.
    always_comb begin
        dec        = '0;
        dec.opcode = in_insn[OPC_LSB +: OPC_W];
        dec.dst    = in_insn[DST_LSB +: REG_W];
        dec.src1   = in_insn[SRC1_LSB +: REG_W];
        dec.src2   = in_insn[SRC2_LSB +: REG_W];
        dec.imm    = {{(32-IMM_W){in_insn[IMM_LSB+IMM_W-1]}},
                      in_insn[IMM_LSB +: IMM_W]};
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec.illegal   = !is_defined_op(dec.opcode);
        dec.is_branch = is_control_flow(dec.opcode) && !dec.illegal;
        dec.is_mem    = is_memory_op(dec.opcode) && !dec.illegal;
`else
        dec.is_branch = is_control_flow(dec.opcode);
        dec.is_mem    = is_memory_op(dec.opcode);
`endif
    end

    assign buf_in = {in_exec_mask, in_pc, dec};

    decode_skid_buffer #(
        .W(W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_busy  (in_busy),
        .in_data  (buf_in),
        .out_valid(out_valid),
        .out_busy (out_busy),
        .out_data (buf_out)
    );

    assign {out_exec_mask, out_pc, head} = buf_out;

    assign out_opcode    = head.opcode;
    assign out_dst       = head.dst;
    assign out_src1      = head.src1;
    assign out_src2      = head.src2;
    assign out_imm       = head.imm;
    assign out_is_branch = head.is_branch;
    assign out_is_mem    = head.is_mem;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign out_illegal   = head.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instruction vectors,
// expected records queued at transfer time and checked on each pop.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_busy;
    logic [7:0]  in_exec_mask = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_insn = '0;
    logic        out_valid;
    logic        out_busy = 1'b0;
    logic [7:0]  out_exec_mask;
    logic [31:0] out_pc;
    logic [7:0]  out_opcode;
    logic [3:0]  out_dst;
    logic [3:0]  out_src1;
    logic [3:0]  out_src2;
    logic [31:0] out_imm;
    logic        out_is_branch;
    logic        out_is_mem;
    logic        ill_seen;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic ILL = 1'b1;
    logic out_illegal;
    assign ill_seen = out_illegal;
`else
    localparam logic ILL = 1'b0;
    assign ill_seen = 1'b0;
`endif

    decode_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_busy      (in_busy),
        .in_exec_mask (in_exec_mask),
        .in_pc        (in_pc),
        .in_insn      (in_insn),
        .out_valid    (out_valid),
        .out_busy     (out_busy),
        .out_exec_mask(out_exec_mask),
        .out_pc       (out_pc),
        .out_opcode   (out_opcode),
        .out_dst      (out_dst),
        .out_src1     (out_src1),
        .out_src2     (out_src2),
        .out_imm      (out_imm),
        .out_is_branch(out_is_branch),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .out_is_mem   (out_is_mem),
        .out_illegal  (out_illegal)
`else
        .out_is_mem   (out_is_mem)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mask;
        logic [31:0] pc;
        logic [7:0]  op;
        logic [3:0]  dst;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [31:0] imm;
        logic        br;
        logic        mem;
        logic        ill;
    } exp_t;

    exp_t sbq[$];
    int   pop_cyc[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   epoch = 0;
    int   n_out = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: pop-and-compare on every accepted output, hold check while stalled
    logic        held = 1'b0;
    int          held_epoch = 0;
    logic [31:0] h_pc;
    logic [7:0]  h_op;
    logic [31:0] h_imm;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (held && held_epoch == epoch) begin
                total++;
                if (out_pc !== h_pc || out_opcode !== h_op || out_imm !== h_imm) begin
                    bad++;
                    $display("FAIL hold got pc=%h op=%h imm=%h exp pc=%h op=%h imm=%h",
                             out_pc, out_opcode, out_imm, h_pc, h_op, h_imm);
                end
            end
            if (out_valid && !out_busy) begin
                total++;
                n_out++;
                pop_cyc.push_back(cyc);
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out got pc=%h exp none", out_pc);
                end else begin
                    e = sbq.pop_front();
                    if (out_pc !== e.pc || out_exec_mask !== e.mask ||
                        out_opcode !== e.op || out_dst !== e.dst ||
                        out_src1 !== e.s1 || out_src2 !== e.s2 ||
                        out_imm !== e.imm || out_is_branch !== e.br ||
                        out_is_mem !== e.mem || ill_seen !== e.ill) begin
                        bad++;
                        $display("FAIL out_pkt got pc=%h m=%h op=%h d=%h s1=%h s2=%h imm=%h br=%b mem=%b ill=%b exp pc=%h m=%h op=%h d=%h s1=%h s2=%h imm=%h br=%b mem=%b ill=%b",
                                 out_pc, out_exec_mask, out_opcode, out_dst, out_src1,
                                 out_src2, out_imm, out_is_branch, out_is_mem, ill_seen,
                                 e.pc, e.mask, e.op, e.dst, e.s1, e.s2, e.imm,
                                 e.br, e.mem, e.ill);
                    end
                end
            end
            held       <= out_valid && out_busy;
            held_epoch <= epoch;
            h_pc       <= out_pc;
            h_op       <= out_opcode;
            h_imm      <= out_imm;
        end else begin
            held <= 1'b0;
        end
    end

    task automatic send(input logic [31:0] pc, input logic [31:0] insn,
                        input logic [7:0] mask, input logic br,
                        input logic mem, input logic ill, output int stalls);
        exp_t e;
        stalls = 0;
        @(posedge clk);
        #1;
        in_valid     = 1'b1;
        in_pc        = pc;
        in_insn      = insn;
        in_exec_mask = mask;
        @(negedge clk);
        while (in_busy && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        if (in_busy) begin
            total++;
            bad++;
            $display("FAIL send_timeout got busy=1 exp busy=0 pc=%h", pc);
        end else begin
            e.mask = mask;
            e.pc   = pc;
            e.op   = insn[7:0];
            e.dst  = insn[11:8];
            e.s1   = insn[15:12];
            e.s2   = insn[19:16];
            e.imm  = {{16{insn[31]}}, insn[31:16]};
            e.br   = br;
            e.mem  = mem;
            e.ill  = ill;
            sbq.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [31:0] s_insn [10] = '{
        32'h0005_4301, 32'h8000_1202, 32'h0010_0510, 32'hFFFC_6011,
        32'h0008_0022, 32'h0000_0712, 32'h1234_5601, 32'h0000_00FE,
        32'h7FFF_0020, 32'h0002_0021};
    logic s_br  [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1};
    logic s_mem [10] = '{0, 0, 1, 1, 0, 1, 0, 0, 0, 0};
    logic s_ill [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    initial begin
        int st;
        int st_sum;
        int n0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_busy", {31'b0, in_busy}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_opcode", {24'b0, out_opcode}, 32'd0);
        check("rst_out_imm", out_imm, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(32'h100, 32'hFFF3_2101, 8'hFF, 1'b0, 1'b0, 1'b0, st);
        idle();
        @(negedge clk);
        check("lat_valid", {31'b0, out_valid}, 32'd1);
        check("t1_dst", {28'b0, out_dst}, 32'd1);
        check("t1_src1", {28'b0, out_src1}, 32'd2);
        check("t1_src2", {28'b0, out_src2}, 32'd3);
        check("t1_imm", out_imm, 32'hFFFF_FFF3);
        check("t1_branch", {31'b0, out_is_branch}, 32'd0);
        repeat (2) @(negedge clk);

        pop_cyc.delete();
        st_sum = 0;
        for (int i = 0; i < 10; i++) begin
            send(32'h100 + 32'(4 * i), s_insn[i], 8'(8'hA0 + i),
                 s_br[i], s_mem[i], s_ill[i] & ILL, st);
            st_sum += st;
        end
        idle();
        repeat (3) @(negedge clk);
        check("stream_stalls", 32'(st_sum), 32'd0);
        check("stream_count", 32'(pop_cyc.size()), 32'd10);
        if (pop_cyc.size() == 10)
            check("stream_span", 32'(pop_cyc[9] - pop_cyc[0]), 32'd9);

        @(posedge clk);
        #1 out_busy = 1'b1;
        send(32'h200, 32'h0001_2301, 8'h11, 1'b0, 1'b0, 1'b0, st);
        send(32'h204, 32'h0000_4510, 8'h22, 1'b0, 1'b1, 1'b0, st);
        fork
            begin
                repeat (3) @(posedge clk);
                #1 out_busy = 1'b0;
            end
            send(32'h208, 32'hFFFF_6722, 8'h33, 1'b1, 1'b0, 1'b0, st);
        join
        check("bp_stalls", 32'(st), 32'd3);
        send(32'h20C, 32'h0003_8912, 8'h44, 1'b1, 1'b1, 1'b0, st);
        check("bp_resume", 32'(st), 32'd0);
        idle();
        repeat (4) @(negedge clk);
        check("bp_drained", 32'(sbq.size()), 32'd0);

        @(posedge clk);
        #1 out_busy = 1'b1;
        send(32'h300, 32'h0000_1101, 8'h55, 1'b0, 1'b0, 1'b0, st);
        send(32'h304, 32'h0000_2202, 8'h66, 1'b0, 1'b0, 1'b0, st);
        idle();
        @(negedge clk);
        check("full_busy", {31'b0, in_busy}, 32'd1);
        #2 rst_n = 1'b0;
        epoch++;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_in_busy", {31'b0, in_busy}, 32'd0);
        sbq.delete();
        n0 = n_out;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_busy = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_outputs", 32'(n_out - n0), 32'd0);
        check("final_sbq_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
